// File: rtl/pic_pkg.sv
// pic_pkg: shared register addresses, command codes, config field bits and FSM states
package pic_pkg;
    localparam logic [1:0] A_CONFIG = 2'd0;
    localparam logic [1:0] A_IMR    = 2'd1;
    localparam logic [1:0] A_CMD    = 2'd2;
    localparam logic [1:0] A_STAT   = 2'd3;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_NSEOI = 2'b01;
    localparam logic [1:0] CMD_SEOI  = 2'b10;

    localparam int CFG_LTIM = 8;
    localparam int CFG_AEOI = 9;
    localparam int CFG_AROT = 10;
    localparam int CMD_ROT  = 13;

    typedef enum logic [1:0] {IDLE, ACK1_WAIT, ACK2} state_t;
endpackage

// File: rtl/pic_if.sv
// pic_if: CPU-side register bus and interrupt acknowledge handshake
interface pic_if;
    logic        wr_en;
    logic        rd_en;
    logic [1:0]  addr;
    logic [15:0] d_in;
    logic [15:0] d_out;
    logic        vec_valid;
    logic        inta;
    logic        intr;

    modport master (output wr_en, rd_en, addr, d_in, inta, input d_out, vec_valid, intr);
    modport slave  (input wr_en, rd_en, addr, d_in, inta, output d_out, vec_valid, intr);
endinterface

// File: rtl/pic_prio_rotate.sv
// pic_prio_rotate: picks the highest-priority set bit, priority starting just after low_prio
module pic_prio_rotate #(
    parameter  int N_IRQ = 8,
    localparam int ID_W  = $clog2(N_IRQ)
) (
    input  logic [N_IRQ-1:0] vec,
    input  logic [ID_W-1:0]  low_prio,
    output logic             found,
    output logic [ID_W-1:0]  id
);
    int k;

    // scan lowest to highest priority so the highest-priority hit is written last
    always_comb begin
        found = 1'b0;
        id    = '0;
        k     = 0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            k = (int'(low_prio) + 1 + i) % N_IRQ;
            if (vec[k]) begin
                found = 1'b1;
                id    = ID_W'(k);
            end
        end
    end
endmodule

// File: rtl/pic_core_n.sv
// pic_core_n: N-input interrupt controller with nesting, rotation, EOI modes and INTA vector handshake
module pic_core_n
    import pic_pkg::*;
#(
    parameter int         N_IRQ        = 8,
    parameter logic [7:0] RST_VEC_BASE = 8'h00
) (
    input logic             clk,
    input logic             rst_n,
    input logic [N_IRQ-1:0] ir,
    pic_if.slave            bus
);
    localparam int ID_W = $clog2(N_IRQ);
    localparam logic [ID_W-1:0] ID_MAX = ID_W'(N_IRQ - 1);

    state_t state, state_n;
    logic [N_IRQ-1:0] irr, isr, imr, lvl_blk, ir_q;
    logic [N_IRQ-1:0] irr_n, isr_n, imr_n, blk_n, ack_mask, eoi_mask;
    logic [ID_W-1:0] low_prio, cur_id, low_n, cur_n;
    logic [ID_W-1:0] win_id, isr_id, s_id;
    logic [7:0] vec_base;
    logic [15:0] d_out, dout_n;
    logic ltim, aeoi, auto_rot, spur, spur_n, inta_q, intr, intr_n;
    logic win_found, isr_found, inta_rise, cfg_wr, imr_wr, cmd_wr, s_ok;
    logic [1:0] cmd;

    // priority distance from the top of the rotating order; smaller is more urgent
    function automatic logic [ID_W-1:0] rank(input logic [ID_W-1:0] id, input logic [ID_W-1:0] lp);
        return ID_W'((int'(id) - int'(lp) - 1 + 2 * N_IRQ) % N_IRQ);
    endfunction

    pic_prio_rotate #(.N_IRQ(N_IRQ)) u_win (.vec(irr & ~imr), .low_prio(low_prio), .found(win_found), .id(win_id));
    pic_prio_rotate #(.N_IRQ(N_IRQ)) u_isr (.vec(isr), .low_prio(low_prio), .found(isr_found), .id(isr_id));

    assign inta_rise     = bus.inta & ~inta_q;
    assign cfg_wr        = bus.wr_en && bus.addr == A_CONFIG;
    assign imr_wr        = bus.wr_en && bus.addr == A_IMR;
    assign cmd_wr        = bus.wr_en && bus.addr == A_CMD;
    assign cmd           = bus.d_in[15:14];
    assign s_id          = bus.d_in[ID_W-1:0];
    assign s_ok          = int'(s_id) < N_IRQ;
    assign bus.d_out     = d_out;
    assign bus.intr      = intr;
    assign bus.vec_valid = state == ACK2 && bus.inta;
    assign intr_n        = state == IDLE && !inta_rise && !cfg_wr && win_found &&
                           (!isr_found || rank(win_id, low_prio) < rank(isr_id, low_prio));

    // next-state: handshake FSM, register reads, EOI handling, request capture and init
    always_comb begin
        state_n  = state;
        cur_n    = cur_id;
        spur_n   = spur;
        low_n    = low_prio;
        dout_n   = d_out;
        ack_mask = '0;
        eoi_mask = '0;
        if (bus.rd_en && state != ACK2)
            dout_n = bus.addr == A_CONFIG ? {5'b0, auto_rot, aeoi, ltim, vec_base} :
                     bus.addr == A_IMR    ? 16'(imr) :
                     bus.addr == A_CMD    ? 16'(irr) : 16'(isr);
        case (state)
            IDLE: if (inta_rise) begin
                state_n          = ACK1_WAIT;
                cur_n            = win_found ? win_id : ID_MAX;
                spur_n           = !win_found;
                ack_mask[win_id] = win_found;
            end
            ACK1_WAIT: if (inta_rise) begin
                state_n = ACK2;
                dout_n  = {8'h00, vec_base + 8'(cur_id)};
            end
            ACK2: if (!bus.inta) begin
                state_n = IDLE;
                if (aeoi && !spur) begin
                    eoi_mask[cur_id] = 1'b1;
                    low_n            = auto_rot ? cur_id : low_prio;
                end
            end
            default: state_n = IDLE;
        endcase
        if (cmd_wr && cmd == CMD_NSEOI && isr_found) begin
            eoi_mask[isr_id] = 1'b1;
            low_n            = bus.d_in[CMD_ROT] ? isr_id : low_n;
        end
        if (cmd_wr && cmd == CMD_SEOI && s_ok) begin
            eoi_mask[s_id] = 1'b1;
            low_n          = bus.d_in[CMD_ROT] ? s_id : low_n;
        end
        blk_n = (lvl_blk | ack_mask) & ir;
        irr_n = ltim ? ir & ~blk_n : (irr & ~ack_mask) | (ir & ~ir_q);
        isr_n = (isr & ~eoi_mask) | ack_mask;
        imr_n = imr_wr ? bus.d_in[N_IRQ-1:0] : imr;
        if (cfg_wr) begin
            state_n = IDLE;
            irr_n   = '0;
            isr_n   = '0;
            imr_n   = '0;
            blk_n   = '0;
            low_n   = ID_MAX;
            cur_n   = '0;
            spur_n  = 1'b0;
            dout_n  = '0;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            irr      <= '0;
            isr      <= '0;
            imr      <= '0;
            lvl_blk  <= '0;
            ir_q     <= '0;
            low_prio <= ID_MAX;
            cur_id   <= '0;
            spur     <= 1'b0;
            inta_q   <= 1'b0;
            d_out    <= '0;
            intr     <= 1'b0;
            vec_base <= RST_VEC_BASE;
            ltim     <= 1'b0;
            aeoi     <= 1'b0;
            auto_rot <= 1'b0;
        end else begin
            state    <= state_n;
            irr      <= irr_n;
            isr      <= isr_n;
            imr      <= imr_n;
            lvl_blk  <= blk_n;
            ir_q     <= ir;
            low_prio <= low_n;
            cur_id   <= cur_n;
            spur     <= spur_n;
            inta_q   <= bus.inta;
            d_out    <= dout_n;
            intr     <= intr_n;
            if (cfg_wr) begin
                vec_base <= bus.d_in[7:0];
                ltim     <= bus.d_in[CFG_LTIM];
                aeoi     <= bus.d_in[CFG_AEOI];
                auto_rot <= bus.d_in[CFG_AROT];
            end
        end
    end
endmodule

// File: tb/tb_pic_core_n.sv
// tb_pic_core_n: directed scoreboard bench for pic_core_n (8- and 16-input builds)
module tb_pic_core_n;
    logic clk = 0;
    logic rst_n = 0;
    logic [7:0] ir8 = '0;
    logic [15:0] ir16 = '0;
    logic chk = 0, done = 0;
    logic rd8_d = 0, rd16_d = 0, vv8_p = 0, vv16_p = 0;
    logic [15:0] exp_q[$];
    string nm_q[$];
    int checks = 0, errors = 0, cyc = 0;

    pic_if b8();
    pic_if b16();

    pic_core_n #(.N_IRQ(8), .RST_VEC_BASE(8'h00)) u8 (.clk(clk), .rst_n(rst_n), .ir(ir8), .bus(b8));
    pic_core_n #(.N_IRQ(16), .RST_VEC_BASE(8'h40)) u16 (.clk(clk), .rst_n(rst_n), .ir(ir16), .bus(b16));

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] e, input string n);
        exp_q.push_back(e);
        nm_q.push_back(n);
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        b8.wr_en = 1; b8.addr = a; b8.d_in = d;
        step();
        b8.wr_en = 0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [15:0] e, input string n);
        push(e, n);
        b8.rd_en = 1; b8.addr = a;
        step();
        b8.rd_en = 0;
        step();
    endtask

    task automatic chk_int(input logic e, input string n);
        push({15'b0, e}, n);
        chk = 1;
        step();
        chk = 0;
    endtask

    task automatic pulse();
        b8.inta = 1; step();
        b8.inta = 0; step();
    endtask

    task automatic vphase(input logic [15:0] v, input string n);
        push(v, n);
        b8.inta = 1; step(2);
        b8.inta = 0; step();
    endtask

    task automatic ack(input logic [15:0] v, input string n);
        pulse();
        vphase(v, n);
    endtask

    task automatic cmp(input logic [15:0] act);
        logic [15:0] e;
        string n;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got %h, none expected", act);
        end else begin
            e = exp_q.pop_front();
            n = nm_q.pop_front();
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", n, act, e);
            end
        end
    endtask

    // read strobes seen at a clock edge produce d_out checks on the following negedge
    always @(posedge clk) begin
        rd8_d  <= b8.rd_en;
        rd16_d <= b16.rd_en;
    end

    // monitor: pops the scoreboard whenever a DUT presents a read, a vector or an INT sample
    always @(negedge clk) begin
        cyc++;
        if (rd8_d) cmp(b8.d_out);
        if (b8.vec_valid && !vv8_p) cmp(b8.d_out);
        if (chk) cmp({15'b0, b8.intr});
        if (rd16_d) cmp(b16.d_out);
        if (b16.vec_valid && !vv16_p) cmp(b16.d_out);
        vv8_p  = b8.vec_valid;
        vv16_p = b16.vec_valid;
        if (done || cyc > 20000) begin
            if (!done) begin
                errors++;
                $display("FAIL timeout: got %0d cycles, limit 20000", cyc);
            end
            if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL missing_outputs: got %0d pending, expected 0", exp_q.size());
            end
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
    end

    initial begin
        b8.wr_en = 0; b8.rd_en = 0; b8.addr = 0; b8.d_in = 0; b8.inta = 0;
        b16.wr_en = 0; b16.rd_en = 0; b16.addr = 0; b16.d_in = 0; b16.inta = 0;
        step(2);
        rst_n = 1;
        step();
        chk_int(0, "rst_int");
        rd(2'd0, 16'h0000, "rst_cfg");
        rd(2'd1, 16'h0000, "rst_imr");
        rd(2'd3, 16'h0000, "rst_isr");
        push(16'h0040, "rst_cfg16");
        b16.rd_en = 1; b16.addr = 2'd0; step(); b16.rd_en = 0; step();

        // edge trigger with auto EOI
        wr(2'd0, 16'h0220);
        rd(2'd0, 16'h0220, "cfg_rb");
        ir8 = 8'h08;
        step();
        chk_int(0, "int_lat1");
        chk_int(1, "int_edge");
        pulse();
        rd(2'd3, 16'h0008, "ack1_isr");
        rd(2'd2, 16'h0000, "ack1_irr");
        chk_int(0, "ack1_int");
        vphase(16'h0023, "vec_aeoi");
        rd(2'd3, 16'h0000, "aeoi_isr");
        chk_int(0, "aeoi_int");
        ir8 = 8'h00;

        // fully nested, normal EOI
        wr(2'd0, 16'h0020);
        ir8 = 8'h20;
        step(2);
        chk_int(1, "int5");
        ack(16'h0025, "vec5");
        rd(2'd3, 16'h0020, "isr5");
        ir8 = 8'h24;
        step(2);
        chk_int(1, "int_nest");
        ack(16'h0022, "vec_nest");
        rd(2'd3, 16'h0024, "isr_nest");
        wr(2'd2, 16'h4000);
        rd(2'd3, 16'h0020, "nseoi1");
        ir8 = 8'h64;
        step(2);
        chk_int(0, "int6_blocked");
        wr(2'd2, 16'h4000);
        step();
        chk_int(1, "int6_after_eoi");

        // level trigger and masking
        ir8 = 8'h00;
        wr(2'd0, 16'h0120);
        wr(2'd1, 16'h0010);
        ir8 = 8'h10;
        step(2);
        rd(2'd2, 16'h0010, "lvl_irr");
        chk_int(0, "lvl_masked");
        wr(2'd1, 16'h0000);
        chk_int(0, "imr_latency");
        chk_int(1, "lvl_int");
        ir8 = 8'h00;
        step(2);
        rd(2'd2, 16'h0000, "lvl_drop_irr");
        chk_int(0, "lvl_drop_int");

        // rotation via specific EOI with ROT
        wr(2'd0, 16'h0020);
        ir8 = 8'h42;
        step(2);
        wr(2'd2, 16'hA001);
        ack(16'h0026, "vec_rot");
        rd(2'd3, 16'h0040, "rot_isr");
        rd(2'd2, 16'h0002, "rot_irr");
        wr(2'd2, 16'h4000);
        ir8 = 8'h43;
        step(2);
        wr(2'd2, 16'hA000);
        wr(2'd2, 16'hA007);
        ack(16'h0020, "vec_wrap");

        // spurious acknowledge
        ir8 = 8'h00;
        wr(2'd0, 16'h0020);
        step();
        pulse();
        rd(2'd3, 16'h0000, "spur_isr");
        vphase(16'h0027, "spur_vec");
        rd(2'd3, 16'h0000, "spur_isr_end");
        b16.inta = 1; step(); b16.inta = 0; step();
        push(16'h004F, "spur_vec16");
        b16.inta = 1; step(2); b16.inta = 0; step();

        // init write mid-handshake
        ir8 = 8'h04;
        step(2);
        pulse();
        rd(2'd3, 16'h0004, "mid_isr");
        wr(2'd0, 16'h0020);
        rd(2'd3, 16'h0000, "init_isr");
        rd(2'd2, 16'h0000, "init_irr");
        chk_int(0, "init_int");
        ack(16'h0027, "init_first_pulse");

        // async reset mid-handshake
        ir8 = 8'h00;
        pulse();
        #2 rst_n = 0;
        #3 rst_n = 1;
        step();
        rd(2'd0, 16'h0000, "rst2_cfg");
        rd(2'd3, 16'h0000, "rst2_isr");
        chk_int(0, "rst2_int");
        ack(16'h0007, "rst2_vec");

        step(3);
        done = 1;
    end
endmodule
